// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic ID_IF = 1'b0;
  localparam logic ID_LS = 1'b1;

  localparam int AW_DEF      = 16;
  localparam int DW_DEF      = 16;
  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to whoever did not win last.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  always_comb begin
    winner = last;
    case (req)
      2'b01:   winner = ID_IF;
      2'b10:   winner = ID_LS;
      2'b11:   winner = ~last;
      default: winner = last;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one memory port
// with an mfc handshake and a bounded wait.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          ls_req,
  input  logic          ls_rw,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          if_gnt,
  output logic          ls_gnt,
  output logic          if_done,
  output logic          ls_done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mfc
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_e        state_q;
  logic          last_gnt_q;
  logic [7:0]    cnt_q;
  logic          if_gnt_q, ls_gnt_q, if_done_q, ls_done_q, err_q, mem_en_q, mem_rw_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q, rdata_q;
  logic          win;
  logic [7:0]    cnt_d;

  arb_rr2 u_rr (
    .req    ({ls_req, if_req}),
    .last   (last_gnt_q),
    .winner (win)
  );

  assign cnt_d = cnt_q + 8'd1;

  // The mem_* registers double as the latched request, so GRANT already presents them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_gnt_q  <= ID_LS;
      cnt_q       <= '0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (if_req || ls_req) begin
            last_gnt_q  <= win;
            if_gnt_q    <= (win == ID_IF);
            ls_gnt_q    <= (win == ID_LS);
            mem_addr_q  <= (win == ID_LS) ? ls_addr  : if_addr;
            mem_rw_q    <= (win == ID_LS) ? ls_rw    : 1'b1;
            mem_wdata_q <= (win == ID_LS) ? ls_wdata : '0;
            state_q     <= S_GRANT;
          end
        end
        S_GRANT: begin
          mem_en_q <= 1'b1;
          cnt_q    <= '0;
          state_q  <= S_ACCESS;
        end
        S_ACCESS: begin
          cnt_q <= cnt_d;
          // mfc wins over a timeout landing in the same cycle
          if (mfc || (cnt_d == TO_LIM)) begin
            mem_en_q  <= 1'b0;
            if_done_q <= (last_gnt_q == ID_IF);
            ls_done_q <= (last_gnt_q == ID_LS);
            err_q     <= ~mfc;
            if (mfc && mem_rw_q) rdata_q <= mem_rdata;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          if_gnt_q <= 1'b0;
          ls_gnt_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_gnt    = if_gnt_q;
  assign ls_gnt    = ls_gnt_q;
  assign if_done   = if_done_q;
  assign ls_done   = ls_done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, store path, alternation, timeout, reset mid-access.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, ls_req = 1'b0, ls_rw = 1'b0;
  logic [15:0] if_addr = '0, ls_addr = '0, ls_wdata = '0, mem_rdata = '0;
  logic        mfc = 1'b0;
  logic        if_gnt, ls_gnt, if_done, ls_done, err, mem_en, mem_rw;
  logic [15:0] rdata, mem_addr, mem_wdata;

  int n_chk = 0, n_fail = 0;
  int mfc_dly = 0, acnt = 0, en_cyc = 0, ovl = 0, n_ifd = 0, n_lsd = 0, n = 0;
  logic seen;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .ls_req(ls_req), .ls_rw(ls_rw), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .if_gnt(if_gnt), .ls_gnt(ls_gnt), .if_done(if_done), .ls_done(ls_done),
    .rdata(rdata), .err(err),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mfc(mfc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: sample on the falling edge, then play the memory (mfc after mfc_dly enabled cycles).
  task automatic tick();
    @(negedge clk);
    if (if_gnt && ls_gnt)   ovl++;
    if (if_done && ls_done) ovl++;
    if (if_done) n_ifd++;
    if (ls_done) n_lsd++;
    if (mem_en) begin en_cyc++; acnt++; end
    else acnt = 0;
    mfc = mem_en && (mfc_dly != 0) && (acnt == mfc_dly);
  endtask

  task automatic run_until_done(input int max);
    n = 0; seen = 1'b0;
    while (!seen && n < max) begin
      tick();
      n++;
      if (if_done || ls_done) seen = 1'b1;
    end
  endtask

  task automatic clr();
    en_cyc = 0; ovl = 0; n_ifd = 0; n_lsd = 0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_gnt",   {30'd0, if_gnt, ls_gnt}, 32'd0);
    chk("rst_done",  {30'd0, if_done, ls_done}, 32'd0);
    chk("rst_mem",   {14'd0, mem_en, mem_rw, mem_addr}, 32'd0);
    chk("rst_data",  {rdata, mem_wdata}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    reset = 1'b0;
    tick();

    // lone fetch, mfc in first ACCESS cycle
    clr(); if_addr = 16'h0040; mem_rdata = 16'hBEEF; mfc_dly = 1; if_req = 1'b1;
    tick();
    chk("t1_grant_en", {30'd0, if_gnt, mem_en}, 32'h2);
    chk("t1_addr", {16'd0, mem_addr}, 32'h0040);
    chk("t1_rw", {31'd0, mem_rw}, 32'd1);
    run_until_done(40);
    chk("t1_latency", n + 1, 32'd3);
    chk("t1_done", {30'd0, if_done, ls_done}, 32'h2);
    chk("t1_rdata", {16'd0, rdata}, 32'hBEEF);
    chk("t1_err", {31'd0, err}, 32'd0);
    if_req = 1'b0; tick();

    // lone store, mfc after 3 cycles; address change mid-access must be ignored
    clr(); ls_addr = 16'h0100; ls_wdata = 16'h1234; ls_rw = 1'b0; mfc_dly = 3; ls_req = 1'b1;
    tick();
    ls_addr = 16'hFFFF; ls_wdata = 16'h5555;
    run_until_done(40);
    chk("t2_latency", n + 1, 32'd5);
    chk("t2_rw", {31'd0, mem_rw}, 32'd0);
    chk("t2_wdata", {16'd0, mem_wdata}, 32'h1234);
    chk("t2_addr", {16'd0, mem_addr}, 32'h0100);
    ls_req = 1'b0; tick(); tick();
    chk("t2_en_cycles", en_cyc, 32'd3);
    chk("t2_done_cnt", {n_lsd[15:0], n_ifd[15:0]}, 32'h0001_0000);

    // both held from reset: IF, LS, IF, LS
    reset = 1'b1; tick();
    clr(); ls_rw = 1'b1; if_req = 1'b1; ls_req = 1'b1; mfc_dly = 1;
    tick(); reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      run_until_done(40);
      chk($sformatf("t3_order%0d", k), {30'd0, if_done, ls_done}, (k % 2 == 0) ? 32'h2 : 32'h1);
    end
    if_req = 1'b0; ls_req = 1'b0; tick();
    chk("t3_overlap", ovl, 32'd0);

    // timeout: mfc never arrives
    clr(); ls_addr = 16'h0200; ls_rw = 1'b1; mfc_dly = 0; mem_rdata = 16'h7777; ls_req = 1'b1;
    run_until_done(60);
    chk("t4_latency", n, 32'd17);
    chk("t4_done_err", {30'd0, ls_done, err}, 32'h3);
    ls_req = 1'b0; tick();
    chk("t4_en_cycles", en_cyc, 32'd15);
    chk("t4_idle", {28'd0, dut.state_q, ls_gnt, err}, {28'd0, S_IDLE, 2'b00});

    // mfc on the timeout cycle wins
    clr(); mfc_dly = 15; mem_rdata = 16'hA5A5; ls_req = 1'b1;
    run_until_done(60);
    chk("t5_latency", n, 32'd17);
    chk("t5_done_err", {30'd0, ls_done, err}, 32'h2);
    chk("t5_rdata", {16'd0, rdata}, 32'hA5A5);
    ls_req = 1'b0; tick();

    // reset in second ACCESS cycle after an IF win
    clr(); mfc_dly = 0; if_addr = 16'h0080; if_req = 1'b1;
    tick(); tick(); tick();
    chk("t6_in_access", {31'd0, mem_en}, 32'd1);
    reset = 1'b1; #1;
    chk("t6_async_en", {30'd0, mem_en, if_gnt}, 32'd0);
    ls_req = 1'b1; clr();
    tick(); tick();
    chk("t6_no_done", n_ifd + n_lsd, 32'd0);
    reset = 1'b0;
    run_until_done(40);
    chk("t6_tie_if", {30'd0, if_done, ls_done}, 32'h2);
    if_req = 1'b0; ls_req = 1'b0; tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 16, address width in bits.
REQ-002 Parameter DW, 16, data width in bits.
REQ-003 Parameter TIMEOUT, 15, maximum ACCESS cycles to wait for mfc, legal range 1..255.
REQ-004 clk  in  1  system clock, rising edge active.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 if_req  in  1  instruction-fetch request; held high until if_done.
REQ-007 if_addr  in  AW  fetch address; always a read.
REQ-008 ls_req  in  1  load/store request; held high until ls_done.
REQ-009 ls_rw  in  1  1 = read (load), 0 = write (store).
REQ-010 ls_addr  in  AW  load/store address.
REQ-011 ls_wdata  in  DW  store data.
REQ-012 if_gnt, ls_gnt  out  1  grant to that requester; high from GRANT through DONE.
REQ-013 if_done, ls_done  out  1  one-cycle completion pulse.
REQ-014 rdata  out  DW  registered read data; valid when done pulses on a read.
REQ-015 err  out  1  one-cycle pulse with done when the access timed out.
REQ-016 mem_en  out  1  memory enable.
REQ-017 mem_rw  out  1  1 = read, 0 = write.
REQ-018 mem_addr  out  AW  memory address.
REQ-019 mem_wdata  out  DW  memory write data.
REQ-020 mem_rdata  in  DW  memory read data; valid when mfc = 1.
REQ-021 mfc  in  1  memory function complete.

Function
REQ-022 The FSM SHALL have states IDLE, GRANT, ACCESS and DONE, and SHALL advance one state per clock except while in ACCESS.
REQ-023 In IDLE with any request high, the block SHALL select a winner, latch its address, rw and wdata, and go to GRANT; with no request it SHALL stay in IDLE.
REQ-024 Arbitration SHALL be round-robin on the last_gnt flag: a single request wins outright, and when both are high the requester not named by last_gnt wins.
REQ-025 last_gnt SHALL update to the winner on the IDLE->GRANT transition.
REQ-026 GRANT SHALL drive mem_addr, mem_rw and mem_wdata from the latched values with mem_en = 0, then go to ACCESS.
REQ-027 ACCESS SHALL hold mem_en = 1 and increment an 8-bit wait counter each cycle.
REQ-028 On mfc = 1 in ACCESS, the block SHALL capture mem_rdata into rdata (reads only) and go to DONE.
REQ-029 If the counter reaches TIMEOUT with mfc = 0, the block SHALL go to DONE with err set; when mfc and timeout coincide, mfc takes priority and err stays 0.
REQ-030 DONE SHALL drop mem_en, pulse the winner's done for one cycle (and err if set), then return to IDLE.
REQ-031 The minimum latency from request to done SHALL be 4 cycles: IDLE, GRANT, one ACCESS cycle with mfc, DONE.
REQ-032 Request inputs and address/data changes after the IDLE->GRANT transition SHALL be ignored until done; the access always completes.
REQ-033 A request still high in the cycle after done SHALL be re-arbitrated normally; with both requesting, grants SHALL alternate.
REQ-034 Grant and done SHALL never be asserted for both requesters in the same cycle.

Reset
REQ-035 On reset, regardless of the current state, the block SHALL enter IDLE asynchronously.
REQ-036 On reset, all outputs, the wait counter and the latched values SHALL be 0.
REQ-037 On reset, last_gnt SHALL be set to LS, so the first tie is granted to IF.
REQ-038 A reset during ACCESS SHALL drop mem_en immediately and produce no done pulse.

Structure
REQ-039 Package mem_arb_pkg SHALL hold the state encoding (2-bit), the requester IDs (IF = 0, LS = 1) and the default AW/DW/TIMEOUT constants.
REQ-040 The 2-way round-robin picker SHALL be a sub-module named arb_rr2: inputs req[1:0] and last, output winner.

Verification
REQ-041 Lone if_req, addr 0x0040, mfc in the 1st ACCESS cycle, mem_rdata 0xBEEF -> if_done in cycle 4, rdata = 0xBEEF, mem_rw = 1, err = 0.
REQ-042 Lone ls_req store, addr 0x0100, wdata 0x1234, mfc after 3 cycles -> mem_rw = 0, mem_wdata = 0x1234, ls_done once, mem_en high 3 cycles.
REQ-043 if_req and ls_req held together from reset for 4 accesses -> grant order IF, LS, IF, LS; no overlapping grant or done.
REQ-044 ls_req with mfc never asserted, TIMEOUT = 15 -> ls_done and err pulse together after 15 ACCESS cycles; FSM back in IDLE.
REQ-045 mfc rising on the TIMEOUT cycle -> done with err = 0.
REQ-046 Reset asserted in the 2nd ACCESS cycle -> mem_en = 0 the same cycle, no done; the next tie is granted to IF.
